// File: rtl/enemy_formation_ctrl.sv
// Eight-enemy invader formation: frame-paced side march with edge drops,
// kill handling and speed-up as the formation thins out.
module enemy_formation_ctrl #(
    parameter int X0       = 50,
    parameter int Y0       = 50,
    parameter int SPACING  = 50,
    parameter int SPRITE_W = 32,
    parameter int STEP_X   = 2,
    parameter int STEP_Y   = 16,
    parameter int X_MIN    = 8,
    parameter int X_MAX    = 600,
    parameter int Y_LIMIT  = 400,
    parameter int V_TRIG   = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  v_counter,
    input  logic        restart,
    input  logic        kill_valid,
    input  logic [2:0]  kill_idx,
    output logic [79:0] pos_x_flat,
    output logic [79:0] pos_y_flat,
    output logic [7:0]  alive,
    output logic        step_pulse,
    output logic        all_dead,
    output logic        reached_bottom
);

    typedef enum logic [1:0] {MOVE_R, MOVE_L, HALT} state_t;

    state_t      state, state_nxt;
    logic [10:0] ox, oy, ox_nxt, oy_nxt;
    logic [7:0]  alive_nxt;
    logic [2:0]  frame_cnt, frame_cnt_nxt;
    logic [9:0]  v_prev;
    logic        tick, do_step, at_right, at_left;
    logic [3:0]  n_alive, half_alive, period;
    logic [2:0]  lo, hi;
    logic [10:0] lo_off, hi_off;

    function automatic logic [79:0] pos_x_of(input logic [10:0] o);
        logic [79:0] r;
        for (int i = 0; i < 8; i++)
            r[10*i +: 10] = 10'(o + 11'(i * SPACING));
        return r;
    endfunction

    function automatic logic [79:0] pos_y_of(input logic [10:0] o);
        return {8{o[9:0]}};
    endfunction

    always_comb begin
        n_alive = '0;
        lo      = '0;
        hi      = '0;
        for (int i = 0; i < 8; i++)
            n_alive = n_alive + {3'b0, alive[i]};
        for (int i = 7; i >= 0; i--)
            if (alive[i]) lo = 3'(i);
        for (int i = 0; i < 8; i++)
            if (alive[i]) hi = 3'(i);
    end

    // Edge limits and period always come from the pre-kill mask of this cycle.
    assign half_alive = n_alive >> 1;
    assign period     = (half_alive == 4'd0) ? 4'd1 : half_alive;
    assign lo_off     = 11'(lo) * 11'(SPACING);
    assign hi_off     = 11'(hi) * 11'(SPACING);
    assign at_right   = (ox + hi_off + 11'(SPRITE_W) + 11'(STEP_X)) > 11'(X_MAX);
    assign at_left    = (ox + lo_off) < 11'(X_MIN + STEP_X);
    assign tick       = (v_counter == 10'(V_TRIG)) && (v_prev != 10'(V_TRIG));
    assign do_step    = tick && (state != HALT) && ({1'b0, frame_cnt} >= (period - 4'd1));

    always_comb begin
        ox_nxt        = ox;
        oy_nxt        = oy;
        state_nxt     = state;
        alive_nxt     = alive;
        frame_cnt_nxt = frame_cnt;
        if (tick && state != HALT)
            frame_cnt_nxt = do_step ? 3'd0 : frame_cnt + 3'd1;
        if (do_step) begin
            unique case (state)
                MOVE_R: begin
                    if (at_right) begin
                        oy_nxt    = oy + 11'(STEP_Y);
                        state_nxt = MOVE_L;
                    end else begin
                        ox_nxt = ox + 11'(STEP_X);
                    end
                end
                MOVE_L: begin
                    if (at_left) begin
                        oy_nxt    = oy + 11'(STEP_Y);
                        state_nxt = MOVE_R;
                    end else begin
                        ox_nxt = ox - 11'(STEP_X);
                    end
                end
                default: ;
            endcase
        end
        if (kill_valid)
            alive_nxt[kill_idx] = 1'b0;
        if (alive_nxt == 8'h00 || oy_nxt >= 11'(Y_LIMIT))
            state_nxt = HALT;
    end

    // Positions and flags register the next-state values so they move on the step edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ox             <= 11'(X0);
            oy             <= 11'(Y0);
            alive          <= 8'hFF;
            state          <= MOVE_R;
            frame_cnt      <= '0;
            v_prev         <= '0;
            step_pulse     <= 1'b0;
            all_dead       <= 1'b0;
            reached_bottom <= 1'b0;
            pos_x_flat     <= pos_x_of(11'(X0));
            pos_y_flat     <= pos_y_of(11'(Y0));
        end else if (restart) begin
            ox             <= 11'(X0);
            oy             <= 11'(Y0);
            alive          <= 8'hFF;
            state          <= MOVE_R;
            frame_cnt      <= '0;
            v_prev         <= '0;
            step_pulse     <= 1'b0;
            all_dead       <= 1'b0;
            reached_bottom <= 1'b0;
            pos_x_flat     <= pos_x_of(11'(X0));
            pos_y_flat     <= pos_y_of(11'(Y0));
        end else begin
            ox             <= ox_nxt;
            oy             <= oy_nxt;
            alive          <= alive_nxt;
            state          <= state_nxt;
            frame_cnt      <= frame_cnt_nxt;
            v_prev         <= v_counter;
            step_pulse     <= do_step;
            all_dead       <= (alive_nxt == 8'h00);
            reached_bottom <= (oy_nxt >= 11'(Y_LIMIT));
            pos_x_flat     <= pos_x_of(ox_nxt);
            pos_y_flat     <= pos_y_of(oy_nxt);
        end
    end

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Scoreboard bench for enemy_formation_ctrl: a reference model predicts each
// step's positions, the monitor pops and compares them on every step_pulse.
module tb_enemy_formation_ctrl;

    logic        clk = 1'b0;
    logic        reset, restart, kill_valid;
    logic [9:0]  v_counter;
    logic [2:0]  kill_idx;
    logic [79:0] pos_x_flat, pos_y_flat;
    logic [7:0]  alive;
    logic        step_pulse, all_dead, reached_bottom;

    always #5 clk = ~clk;

    enemy_formation_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .v_counter      (v_counter),
        .restart        (restart),
        .kill_valid     (kill_valid),
        .kill_idx       (kill_idx),
        .pos_x_flat     (pos_x_flat),
        .pos_y_flat     (pos_y_flat),
        .alive          (alive),
        .step_pulse     (step_pulse),
        .all_dead       (all_dead),
        .reached_bottom (reached_bottom)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int px(input int i);
        return int'(pos_x_flat[10*i +: 10]);
    endfunction

    function automatic int py(input int i);
        return int'(pos_y_flat[10*i +: 10]);
    endfunction

    typedef struct {int x0; int x7; int y;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   pulse_cnt = 0;

    // Reference model of the formation
    int       m_ox, m_oy, m_cnt, m_dir, m_steps;
    bit       m_halt;
    logic [7:0] m_alive;

    function automatic void model_reset();
        m_ox = 50; m_oy = 50; m_cnt = 0; m_dir = 0; m_steps = 0;
        m_halt = 0; m_alive = 8'hFF;
    endfunction

    function automatic void model_tick();
        int n, per, lo, hi, right_edge, left_edge;
        if (m_halt) return;
        n   = $countones(m_alive);
        per = (n / 2 < 1) ? 1 : n / 2;
        if (m_cnt + 1 < per) begin
            m_cnt++;
            return;
        end
        m_cnt = 0;
        lo = 8; hi = -1;
        for (int i = 0; i < 8; i++) begin
            if (m_alive[i] && i < lo) lo = i;
            if (m_alive[i]) hi = i;
        end
        right_edge = m_ox + hi * 50 + 32;
        left_edge  = m_ox + lo * 50;
        if (m_dir == 0) begin
            if (right_edge + 2 > 600) begin m_oy += 16; m_dir = 1; end
            else m_ox += 2;
        end else begin
            if (left_edge - 2 < 8) begin m_oy += 16; m_dir = 0; end
            else m_ox -= 2;
        end
        m_steps++;
        sb.push_back('{m_ox, m_ox + 350, m_oy});
        if (m_oy >= 400) m_halt = 1;
    endfunction

    function automatic void model_kill(input int idx);
        m_alive[idx] = 1'b0;
        if (m_alive == 8'h00) m_halt = 1;
    endfunction

    always @(negedge clk) begin
        if (reset && step_pulse) begin
            pulse_cnt++;
            if (sb.size() == 0) begin
                check("step_unexpected", 32'(step_pulse), 0);
            end else begin
                mon_e = sb.pop_front();
                check("step_x0", px(0), mon_e.x0);
                check("step_x7", px(7), mon_e.x7);
                check("step_y0", py(0), mon_e.y);
                check("step_y7", py(7), mon_e.y);
            end
        end
    end

    task automatic frame(input bit kv, input int ki);
        @(negedge clk);
        v_counter  = 10'd480;
        kill_valid = kv;
        kill_idx   = 3'(ki);
        model_tick();
        if (kv) model_kill(ki);
        @(negedge clk);
        kill_valid = 1'b0;
        @(negedge clk);
        v_counter = 10'd0;
        @(negedge clk);
        check("sb_drain", sb.size(), 0);
    endtask

    task automatic kill(input int idx);
        @(negedge clk);
        kill_valid = 1'b1;
        kill_idx   = 3'(idx);
        model_kill(idx);
        @(negedge clk);
        kill_valid = 1'b0;
        check("kill_alive", alive, m_alive);
        check("kill_all_dead", all_dead, (m_alive == 8'h00));
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        model_reset();
        sb.delete();
        @(negedge clk);
        restart = 1'b0;
        check("rst_alive", alive, 8'hFF);
        check("rst_x0", px(0), 50);
        check("rst_y0", py(0), 50);
    endtask

    initial begin
        int p0, f, guard;
        reset = 1'b0; restart = 1'b0; kill_valid = 1'b0; kill_idx = '0; v_counter = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_x0", px(0), 50);
        check("reset_x7", px(7), 400);
        check("reset_y3", py(3), 50);
        check("reset_alive", alive, 8'hFF);
        check("reset_pulse", step_pulse, 0);
        check("reset_flags", {all_dead, reached_bottom}, 0);
        reset = 1'b1;

        // Four ticks from reset produce exactly one step
        p0 = pulse_cnt;
        repeat (4) frame(0, 0);
        check("t1_pulses", pulse_cnt - p0, 1);
        check("t1_x0", px(0), 52);
        check("t1_x7", px(7), 402);
        check("t1_y_all", pos_y_flat[39:0], {4{10'd50}});

        // Right-edge drop timing
        guard = 0;
        while (m_steps < 83 && guard < 1000) begin frame(0, 0); guard++; end
        check("t2_ox83", px(0), 216);
        while (m_steps < 84 && guard < 1000) begin frame(0, 0); guard++; end
        check("t2_ox84", px(0), 218);
        while (m_steps < 85 && guard < 1000) begin frame(0, 0); guard++; end
        check("t2_drop_x", px(0), 218);
        check("t2_drop_y", py(0), 66);
        while (m_steps < 86 && guard < 1000) begin frame(0, 0); guard++; end
        check("t2_left_x", px(0), 216);
        check("t2_guard", guard < 1000, 1);

        // Seven alive: period 3, drop from ox=268
        do_restart();
        kill(7);
        p0 = pulse_cnt; f = 0;
        while (pulse_cnt == p0 && f < 10) begin frame(0, 0); f++; end
        check("t3_period", f, 3);
        guard = 0;
        while (m_oy == 50 && guard < 500) begin frame(0, 0); guard++; end
        check("t3_drop_ox", px(0), 268);
        check("t3_drop_oy", py(0), 66);

        // Kill everyone, including the already dead enemy 7
        for (int i = 0; i < 8; i++) kill(i);
        check("t4_all_dead", all_dead, 1);
        check("t4_alive", alive, 0);
        p0 = pulse_cnt;
        repeat (3) frame(0, 0);
        check("t4_no_step", pulse_cnt - p0, 0);
        do_restart();
        check("t4_flags", all_dead, 0);

        // Kill coinciding with a step uses the pre-kill edge
        for (int i = 1; i <= 5; i++) kill(i);
        guard = 0;
        while (!(m_ox == 218 && m_dir == 0) && guard < 200) begin frame(0, 0); guard++; end
        check("t5_pre_x", px(0), 218);
        frame(1, 7);
        check("t5_kstep_x", px(0), 218);
        check("t5_kstep_y", py(0), 66);
        check("t5_kstep_alive", alive, 8'h41);

        // Long vertical-blank hold yields a single tick
        @(negedge clk);
        v_counter = 10'd480;
        model_tick();
        p0 = pulse_cnt;
        repeat (2000) @(negedge clk);
        v_counter = 10'd0;
        @(negedge clk);
        check("t5_hold_ticks", pulse_cnt - p0, 1);
        check("t5_hold_sb", sb.size(), 0);

        // March to the bottom
        guard = 0;
        while (!m_halt && guard < 5000) begin frame(0, 0); guard++; end
        check("t6_guard", guard < 5000, 1);
        check("t6_bottom", reached_bottom, 1);
        check("t6_y", py(0), 402);
        p0 = pulse_cnt;
        repeat (3) frame(0, 0);
        check("t6_halt", pulse_cnt - p0, 0);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("ar_x0", px(0), 50);
        check("ar_y0", py(0), 50);
        check("ar_alive", alive, 8'hFF);
        check("ar_flags", {step_pulse, all_dead, reached_bottom}, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        sb.delete();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
